// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory,
// a single held instruction for decode, and redirect/flush handling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | just out of reset, request starts next cycle
// S_REQ   | imem_req asserted at fetch_pc, waiting for grant
// S_WAIT  | request granted, waiting for read data
// S_VALID | instruction held and presented to decode
// S_DROP  | granted request was flushed, discard its read data
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        load_instr;
  logic [31:0] redirect_tgt;

  // Low address bits of the redirect target are dropped to keep fetches word aligned.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Next-state, next fetch address and instruction-capture decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    load_instr = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          // A granted request is already in flight; its data must be dropped.
          state_d    = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          state_d    = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          load_instr = 1'b1;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          state_d    = S_REQ;
        end else if (instr_ready) begin
          fetch_pc_d = pc_plus4;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and fetch address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Capture the returned instruction together with the address it was fetched from.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else if (load_instr) begin
      pc_q    <= fetch_pc_q;
      instr_q <= imem_rdata;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q & 32'hFFFF_FFFC;
  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_valid ? instr_q : NOP_INSTR;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: one table walks the FSM through
// normal fetch, stalls, every redirect case and address wrap; hand-written
// sequences cover reset state, asynchronous reset in WAIT and stale rvalid.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic red, input logic [31:0] rp,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] ins, input logic [31:0] p,
                              input logic [31:0] p4);
    vec_t t;
    t.gnt = g;   t.rvalid = rv; t.rdata = rd; t.ready = rdy; t.redir = red; t.rpc = rp;
    t.e_req = q; t.e_addr = a;  t.e_valid = v; t.e_instr = ins; t.e_pc = p; t.e_pc4 = p4;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic q, input logic [31:0] a,
                            input logic v, input logic [31:0] ins,
                            input logic [31:0] p, input logic [31:0] p4);
    check({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, q});
    check({tag, ".imem_addr"},   imem_addr,            a);
    check({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, v});
    check({tag, ".instr"},       instr,                ins);
    check({tag, ".pc"},          pc,                   p);
    check({tag, ".pc_plus4"},    pc_plus4,             p4);
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  initial begin
    //        gnt rv rdata         rdy red rpc            req addr          v  instr         pc            pc4
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h4));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(0, 1, 32'h00500113, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00500113, 32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00500113, 32'h0,        32'h4));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00500113, 32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00500113, 32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00500113, 32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h103,      0, 32'h100,      0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        1, 32'h100,      0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(0, 1, 32'h00A00093, 0, 0, 32'h0,        0, 32'h100,      1, 32'h00A00093, 32'h100,      32'h104));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,      0, NOP,          32'h100,      32'h104));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h20,       1, 32'h20,       0, NOP,          32'h100,      32'h104));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h20,       0, NOP,          32'h100,      32'h104));
    vecs.push_back(mk(0, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'h20,       1, 32'h11111111, 32'h20,       32'h24));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h40,       1, 32'h40,       0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h80,       0, 32'h80,       0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h1FE,      0, 32'h1FC,      0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(0, 1, 32'h00000BAD, 0, 0, 32'h0,        1, 32'h1FC,      0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1FC,      0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(0, 1, 32'h00000222, 0, 1, 32'h300,      1, 32'h300,      0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, NOP,          32'h20,       32'h24));
    vecs.push_back(mk(0, 1, 32'h33333333, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h33333333, 32'hFFFFFFFC, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, NOP,          32'hFFFFFFFC, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'hFFFFFFFC, 32'h0));

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
    reset_n = 1'b1;
    #2;
    check_outs("post_release", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4);

    // Table vectors: inputs driven between edges, outputs sampled 1 after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      imem_gnt    = vecs[i].gnt;
      imem_rvalid = vecs[i].rvalid;
      imem_rdata  = vecs[i].rdata;
      instr_ready = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4);
    end

    // Asynchronous reset while in WAIT: outputs must clear before any clock edge.
    idle_inputs();
    #3;
    reset_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
    #2;
    reset_n = 1'b1;

    // Stale rvalid from the abandoned request must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h44444444;
    @(posedge clk);
    #1;
    check_outs("stale_edge1", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
    @(posedge clk);
    #1;
    check_outs("stale_edge2", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
